// File: rtl/dma_tx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dma_tx_pkg
// Purpose  : Register map, register views and entry packing for dma_tx_fifo.
// Revision : 1.0 - initial release
// ============================================================================
package dma_tx_pkg;

    localparam logic [3:0] DTX_TXD = 4'h0;
    localparam logic [3:0] DTX_SR  = 4'h4;
    localparam logic [3:0] DTX_CR  = 4'h8;

    // Entry = {nbytes-1, 32-bit zero-extended data}
    localparam int DTX_ENTRY_W = 34;

    typedef struct packed {
        logic [15:0] rsvd_hi;
        logic [7:0]  lw_thr;
        logic [5:0]  rsvd_lo;
        logic        flush;
        logic        req_en;
    } dtx_cr_v;

    typedef struct packed {
        logic [15:0] rsvd_hi;
        logic [7:0]  level;
        logic [4:0]  rsvd_lo;
        logic        ovf;
        logic        full;
        logic        empty;
    } dtx_sr_v;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } dtx_state_e;

    function automatic logic [DTX_ENTRY_W-1:0] dtx_pack(
        input logic [1:0]  lane,
        input logic [1:0]  size,
        input logic [31:0] wd
    );
        logic [DTX_ENTRY_W-1:0] e;
        case (size)
            2'b00:   e = {2'd0, 24'd0, wd[{lane, 3'b000} +: 8]};
            2'b01:   e = {2'd1, 16'd0, (lane[1] ? wd[31:16] : wd[15:0])};
            default: e = {2'd3, wd};
        endcase
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dma_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : dma_tx_fifo_if
// Purpose  : Slave bus port plus byte-stream output of dma_tx_fifo.
// Revision : 1.0 - initial release
// ============================================================================
interface dma_tx_fifo_if;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [1:0]  size;
    logic        dma_req;
    logic [7:0]  st_data;
    logic        st_valid;
    logic        st_ready;

    modport master (
        output addr, we, wd, size, st_ready,
        input  rd, dma_req, st_data, st_valid
    );

    modport slave (
        input  addr, we, wd, size, st_ready,
        output rd, dma_req, st_data, st_valid
    );
endinterface
`default_nettype wire

// File: rtl/dma_tx_fifo_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with level count and synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 34
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       i_flush,
    input  wire logic                       i_push,
    input  wire logic [W-1:0]               i_wdata,
    input  wire logic                       i_pop,
    output logic      [W-1:0]               o_rdata,
    output logic                            o_full,
    output logic                            o_empty,
    output logic      [$clog2(DEPTH):0]     o_level
);
    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_LVL_W  = c_ADDR_W + 1;

    logic [W-1:0]        r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0]  r_level;
    logic                w_push;
    logic                w_pop;

    // Full/empty come from the pre-cycle level, so a pop cannot make room for a same-cycle push
    assign o_full  = (r_level == c_LVL_W'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_rdata = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            if (w_push && !w_pop)      r_level <= r_level + c_LVL_W'(1);
            else if (!w_push && w_pop) r_level <= r_level - c_LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule
`default_nettype wire

// File: rtl/dma_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : dma_tx_fifo
// Purpose  : Bus-slave byte-stream transmitter with low-water dma refill request.
// Revision : 1.0 - initial release
// ============================================================================
module dma_tx_fifo
    import dma_tx_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  wire logic       clk,
    input  wire logic       rst,
    dma_tx_fifo_if.slave    bus
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [3:0]             w_sel;
    logic                   w_wr_txd;
    logic                   w_wr_sr;
    logic                   w_wr_cr;
    logic                   w_flush;
    logic                   w_push_req;
    logic [DTX_ENTRY_W-1:0] w_entry;
    logic [DTX_ENTRY_W-1:0] w_head;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [LVL_W-1:0]       w_level;
    logic [8:0]             w_level9;
    logic                   w_pop;
    logic                   w_cond;
    logic                   w_unused;

    logic                   r_req_en;
    logic [7:0]             r_lw_thr;
    logic                   r_ovf;
    logic                   r_cond;
    logic                   r_dma_req;
    logic [31:0]            r_rd;
    dtx_sr_v                w_sr;
    dtx_cr_v                w_cr;
    logic [31:0]            w_rd_nxt;

    dtx_state_e             r_state;
    dtx_state_e             w_state_nxt;
    logic [DTX_ENTRY_W-1:0] r_entry;
    logic [DTX_ENTRY_W-1:0] w_entry_nxt;
    logic [1:0]             r_idx;
    logic [1:0]             w_idx_nxt;
    logic                   w_accept;
    logic                   w_last;

    assign w_sel      = {bus.addr[3:2], 2'b00};
    assign w_wr_txd   = bus.we & (w_sel == DTX_TXD);
    assign w_wr_sr    = bus.we & (w_sel == DTX_SR);
    assign w_wr_cr    = bus.we & (w_sel == DTX_CR);
    assign w_flush    = w_wr_cr & bus.wd[1];
    assign w_push_req = w_wr_txd & ~w_flush;
    assign w_entry    = dtx_pack(bus.addr[1:0], bus.size, bus.wd);
    assign w_unused   = ^bus.addr[31:4];

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     (DTX_ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_flush),
        .i_push  (w_push_req),
        .i_wdata (w_entry),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (w_level)
    );

    assign w_level9 = 9'(w_level);
    assign w_cond   = r_req_en & (w_level9 <= {1'b0, r_lw_thr});

    always_comb begin
        w_sr        = '0;
        w_sr.empty  = w_fifo_empty & (r_state == ST_IDLE);
        w_sr.full   = w_fifo_full;
        w_sr.ovf    = r_ovf;
        w_sr.level  = w_level9[7:0];
        w_cr        = '0;
        w_cr.req_en = r_req_en;
        w_cr.lw_thr = r_lw_thr;
        case (w_sel)
            DTX_SR:  w_rd_nxt = w_sr;
            DTX_CR:  w_rd_nxt = w_cr;
            default: w_rd_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_en  <= 1'b0;
            r_lw_thr  <= '0;
            r_ovf     <= 1'b0;
            r_cond    <= 1'b0;
            r_dma_req <= 1'b0;
            r_rd      <= '0;
        end else begin
            if (w_wr_cr) begin
                r_req_en <= bus.wd[0];
                r_lw_thr <= bus.wd[15:8];
            end
            if (w_wr_sr && bus.wd[2])        r_ovf <= 1'b0;
            else if (w_push_req && w_fifo_full) r_ovf <= 1'b1;
            r_cond    <= w_cond;
            r_dma_req <= w_cond & ~r_cond;
            r_rd      <= w_rd_nxt;
        end
    end

    // Unpacker: one held entry, bytes leave LSB first; the next entry loads on the last accept
    assign w_accept = (r_state == ST_SEND) & bus.st_ready;
    assign w_last   = (r_idx == r_entry[DTX_ENTRY_W-1 -: 2]);

    always_comb begin
        w_state_nxt = r_state;
        w_entry_nxt = r_entry;
        w_idx_nxt   = r_idx;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_entry_nxt = w_head;
                    w_idx_nxt   = 2'd0;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_accept) begin
                    if (!w_last) begin
                        w_idx_nxt = r_idx + 2'd1;
                    end else if (!w_fifo_empty) begin
                        w_pop       = 1'b1;
                        w_entry_nxt = w_head;
                        w_idx_nxt   = 2'd0;
                    end else begin
                        w_idx_nxt   = 2'd0;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_flush) begin
            w_pop       = 1'b0;
            w_idx_nxt   = 2'd0;
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_entry <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_entry <= w_entry_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    assign bus.st_valid = (r_state == ST_SEND);
    assign bus.st_data  = r_entry[{r_idx, 3'b000} +: 8];
    assign bus.dma_req  = r_dma_req;
    assign bus.rd       = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_dma_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_tx_fifo
// Purpose  : Randomized self-checking bench against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_tx_fifo;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    dma_tx_fifo_if bus ();

    dma_tx_fifo #(.DEPTH(DEPTH)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO as a queue of entries, held entry as a queue of pending bytes
    logic [33:0] m_q[$];
    logic [7:0]  m_held[$];
    logic        m_ovf;
    logic        m_req_en;
    logic [7:0]  m_lw;
    logic [31:0] m_rd;
    logic        m_cond_prev;
    logic        m_req;
    int          m_in_bytes;
    logic [7:0]  obs[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [33:0] ref_entry(input logic [31:0] a, input logic [31:0] d,
                                              input logic [1:0] s);
        int unsigned nb;
        int unsigned data;
        case (s)
            2'd0:    begin nb = 1; data = (d >> (8 * a[1:0])) & 32'hFF; end
            2'd1:    begin nb = 2; data = a[1] ? (d >> 16) : (d & 32'hFFFF); end
            default: begin nb = 4; data = d; end
        endcase
        return {2'(nb - 1), data};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_held.delete();
        m_ovf = 0; m_req_en = 0; m_lw = 0; m_rd = 0;
        m_cond_prev = 0; m_req = 0;
    endtask

    task automatic model_step();
        int          n;
        bit          held, acc, pop, cond, flush;
        logic [1:0]  sel;
        logic [33:0] front;
        n     = m_q.size();
        held  = (m_held.size() > 0);
        acc   = held && bus.st_ready;
        sel   = bus.addr[3:2];
        case (sel)
            2'd1:    m_rd = ((n & 32'hFF) << 8) | (32'(m_ovf) << 2) |
                            (32'(n == DEPTH) << 1) | 32'(n == 0 && !held);
            2'd2:    m_rd = (32'(m_lw) << 8) | 32'(m_req_en);
            default: m_rd = 0;
        endcase
        cond        = m_req_en && (n <= m_lw);
        m_req       = cond && !m_cond_prev;
        m_cond_prev = cond;
        flush = bus.we && sel == 2'd2 && bus.wd[1];
        if (bus.we && sel == 2'd2) begin
            m_req_en = bus.wd[0];
            m_lw     = bus.wd[15:8];
        end
        if (bus.we && sel == 2'd1 && bus.wd[2]) m_ovf = 0;
        if (flush) begin
            m_q.delete();
            m_held.delete();
            return;
        end
        pop = (n > 0) && (!held || (acc && m_held.size() == 1));
        if (acc) void'(m_held.pop_front());
        front = '0;
        if (pop) front = m_q.pop_front();
        if (bus.we && sel == 2'd0) begin
            if (n == DEPTH) m_ovf = 1;
            else begin
                m_q.push_back(ref_entry(bus.addr, bus.wd, bus.size));
                m_in_bytes += int'(bus.size == 2'd0 ? 1 : bus.size == 2'd1 ? 2 : 4);
            end
        end
        if (pop) for (int i = 0; i <= int'(front[33:32]); i++)
            m_held.push_back(8'(front[31:0] >> (8 * i)));
    endtask

    task automatic check_outputs();
        check("st_valid", 32'(bus.st_valid), 32'(m_held.size() > 0));
        if (m_held.size() > 0) check("st_data", 32'(bus.st_data), 32'(m_held[0]));
        check("dma_req", 32'(bus.dma_req), 32'(m_req));
        check("rd", bus.rd, m_rd);
    endtask

    task automatic cyc();
        if (bus.st_valid && bus.st_ready) obs.push_back(bus.st_data);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        bus.we = 0;
        repeat (n) cyc();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        bus.addr = a; bus.wd = d; bus.size = s; bus.we = 1;
        cyc();
        bus.we = 0;
    endtask

    task automatic rdreg(input logic [31:0] a, output logic [31:0] v);
        bus.addr = a; bus.we = 0;
        cyc();
        v = bus.rd;
    endtask

    task automatic do_reset();
        #2 rst = 1;
        #1;
        model_reset();
        check("rst_st_valid", 32'(bus.st_valid), 32'd0);
        check("rst_dma_req", 32'(bus.dma_req), 32'd0);
        check("rst_st_data", 32'(bus.st_data), 32'd0);
        @(negedge clk);
        check("rst_rd", bus.rd, 32'd0);
        rst = 0;
    endtask

    task automatic check_obs(input string tag, input logic [7:0] exp[$]);
        check({tag, "_count"}, obs.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            check(tag, (i < obs.size()) ? 32'(obs[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] words[$];
        logic [7:0]  exp_b[$];
        int          pulses, acc_at_pulse;

        bus.addr = 0; bus.we = 0; bus.wd = 0; bus.size = 0; bus.st_ready = 0;
        m_in_bytes = 0;
        do_reset();

        // Reset mid-stream
        wr(32'h0, 32'hDEAD_BEEF, 2'd2);
        idle(2);
        check("pre_rst_valid", 32'(bus.st_valid), 32'd1);
        do_reset();
        rdreg(32'h4, v);
        check("t1_sr", v, 32'h0000_0001);

        // Word push drains LSB first
        obs.delete();
        bus.st_ready = 1;
        wr(32'h0, 32'hA1B2_C3D4, 2'd2);
        idle(6);
        exp_b = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        check_obs("t2_bytes", exp_b);
        rdreg(32'h4, v);
        check("t2_sr", v, 32'h0000_0001);

        // Byte/half lane extraction, size 11 as word
        obs.delete();
        wr(32'h1, 32'h0000_5500, 2'd0);
        wr(32'h2, 32'h1234_0000, 2'd1);
        wr(32'h0, 32'hCAFE_F00D, 2'd3);
        idle(10);
        exp_b = '{8'h55, 8'h34, 8'h12, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
        check_obs("t3_bytes", exp_b);

        // Overflow: one held entry plus DEPTH queued, the next push is dropped
        obs.delete();
        words.delete();
        bus.st_ready = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            words.push_back($urandom);
            wr(32'h0, words[i], 2'd2);
        end
        rdreg(32'h4, v);
        check("t4_sr_ovf", v, 32'h0000_1006);
        wr(32'h4, 32'h4, 2'd0);
        rdreg(32'h4, v);
        check("t4_sr_clr", v, 32'h0000_1002);
        bus.st_ready = 1;
        idle(4 * (DEPTH + 1) + 8);
        exp_b.delete();
        for (int i = 0; i < DEPTH + 1; i++)
            for (int j = 0; j < 4; j++) exp_b.push_back(8'(words[i] >> (8 * j)));
        check_obs("t4_bytes", exp_b);

        // Low-water dma_req: level 4 -> 0 with threshold 2
        obs.delete();
        bus.st_ready = 0;
        for (int i = 0; i < 5; i++) wr(32'h0, 32'(8'h10 + i), 2'd0);
        idle(2);
        wr(32'h8, 32'h0000_0201, 2'd0);
        bus.st_ready = 1;
        pulses = 0; acc_at_pulse = -1;
        for (int i = 0; i < 14; i++) begin
            cyc();
            if (bus.dma_req) begin
                pulses++;
                acc_at_pulse = obs.size();
            end
        end
        check("t5_pulses", pulses, 1);
        check("t5_pulse_pos", acc_at_pulse, 3);
        wr(32'h8, 32'h0, 2'd0);

        // Flush while a byte is stalled; new threshold still latched
        bus.st_ready = 0;
        wr(32'h0, 32'h1111_2222, 2'd2);
        wr(32'h0, 32'h3333_4444, 2'd2);
        wr(32'h8, 32'h0000_0502, 2'd0);
        check("t6_st_valid", 32'(bus.st_valid), 32'd0);
        rdreg(32'h4, v);
        check("t6_sr", v, 32'h0000_0001);
        rdreg(32'h8, v);
        check("t6_cr", v, 32'h0000_0500);
        wr(32'h8, 32'h0, 2'd0);

        // Random back-pressure with half-word pushes
        obs.delete();
        m_in_bytes = 0;
        for (int i = 0; i < 600; i++) begin
            bus.st_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0) begin
                bus.addr = 32'($urandom_range(0, 1) * 2);
                bus.wd   = $urandom;
                bus.size = 2'd1;
                bus.we   = 1;
            end else begin
                bus.we   = 0;
                bus.addr = 32'($urandom_range(1, 3) * 4);
            end
            cyc();
        end
        bus.we = 0;
        bus.st_ready = 1;
        idle(2 * DEPTH + 2 * 2 + 8);
        check("t7_count", obs.size(), m_in_bytes);
        rdreg(32'h4, v);
        check("t7_sr", v & 32'h0000_FF03, 32'h0000_0001);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
